// File: rtl/frame_buffer_writer.sv
// Queues filtered sprite pixels into a small FIFO and drains them to the
// frame-buffer memory port, swapping front/back buffers once all pending writes land.
module frame_buffer_writer #(
    parameter int         FIFO_DEPTH  = 8,
    parameter logic [7:0] TRANSPARENT = 8'hE3,
    parameter int         FB_W        = 320,
    parameter int         FB_H        = 240
) (
    input  logic        CLOCK_50,
    input  logic        RESET_H,
    input  logic [7:0]  PIXEL_DIN,
    input  logic [8:0]  PIXEL_X,
    input  logic [8:0]  PIXEL_Y,
    input  logic        WE_IN,
    input  logic        SWAP_REQ,
    input  logic        MEM_ACK,
    output logic [17:0] MEM_ADDR,
    output logic [7:0]  MEM_DATA,
    output logic        MEM_WE,
    output logic        FRONT_SEL,
    output logic        SWAP_DONE,
    output logic        FULL,
    output logic        EMPTY,
    output logic        OVERFLOW
);

    localparam int           AW      = $clog2(FIFO_DEPTH);
    localparam int           EW      = 26;
    localparam logic [8:0]   FB_W9   = 9'(FB_W);
    localparam logic [8:0]   FB_H9   = 9'(FB_H);
    localparam logic [AW:0]  DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, SWAP} state_t;

    state_t         state_q, state_d;
    logic           stgValid_q;
    logic [16:0]    stgAddr_q;
    logic [7:0]     stgData_q;
    logic [EW-1:0]  fifoMem [FIFO_DEPTH];
    logic [AW-1:0]  wrPtr_q, rdPtr_q;
    logic [AW:0]    count_q, count_d;
    logic           frontSel_q, swapPend_q, swapPend_d, overflow_q;
    logic           pixelOk, fifoFull, fifoEmpty, pop, pushOk;
    logic [16:0]    offset;
    logic [EW-1:0]  head;

    assign pixelOk = WE_IN && (PIXEL_DIN != TRANSPARENT) &&
                     (PIXEL_X < FB_W9) && (PIXEL_Y < FB_H9);
    assign offset  = 17'(PIXEL_Y) * 17'(FB_W) + 17'(PIXEL_X);

    always_ff @(posedge CLOCK_50) begin
        if (RESET_H) begin
            stgValid_q <= 1'b0;
            stgAddr_q  <= '0;
            stgData_q  <= '0;
        end else begin
            stgValid_q <= pixelOk;
            if (pixelOk) begin
                stgAddr_q <= offset;
                stgData_q <= PIXEL_DIN;
            end
        end
    end

    assign fifoFull  = (count_q == DEPTH_C);
    assign fifoEmpty = (count_q == '0);
    assign pop       = (state_q == WRITE) && MEM_ACK;
    // A push into a full FIFO survives only if the head leaves in the same cycle.
    assign pushOk    = stgValid_q && (!fifoFull || pop);
    assign count_d   = count_q + {{AW{1'b0}}, pushOk} - {{AW{1'b0}}, pop};
    assign head      = fifoMem[rdPtr_q];

    always_ff @(posedge CLOCK_50) begin
        if (pushOk) begin
            fifoMem[wrPtr_q] <= {~frontSel_q, stgAddr_q, stgData_q};
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET_H) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (pushOk) wrPtr_q <= wrPtr_q + 1'b1;
            if (pop)    rdPtr_q <= rdPtr_q + 1'b1;
            if (stgValid_q && !pushOk) overflow_q <= 1'b1;
        end
    end

    // A request arriving during the swap cycle itself stays pending for the next frame.
    assign swapPend_d = SWAP_REQ || (swapPend_q && (state_q != SWAP));

    always_ff @(posedge CLOCK_50) begin
        if (RESET_H) begin
            state_q    <= IDLE;
            frontSel_q <= 1'b0;
            swapPend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            swapPend_q <= swapPend_d;
            if (state_q == SWAP) frontSel_q <= ~frontSel_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!fifoEmpty)
                    state_d = WRITE;
                else if (swapPend_q && !stgValid_q && !WE_IN)
                    state_d = SWAP;
            end
            WRITE: begin
                if (pop && (count_d == '0)) state_d = IDLE;
            end
            SWAP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign MEM_WE    = (state_q == WRITE);
    assign MEM_ADDR  = MEM_WE ? head[25:8] : 18'd0;
    assign MEM_DATA  = MEM_WE ? head[7:0]  : 8'd0;
    assign FRONT_SEL = frontSel_q;
    assign SWAP_DONE = (state_q == SWAP);
    assign FULL      = fifoFull;
    assign EMPTY     = fifoEmpty && !stgValid_q && (state_q == IDLE);
    assign OVERFLOW  = overflow_q;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed bench for frame_buffer_writer: reset, latency, filtering,
// backpressure/overflow, swap ordering and reset during a stalled write.
module tb_frame_buffer_writer;

    logic        CLOCK_50 = 1'b0;
    logic        RESET_H;
    logic [7:0]  PIXEL_DIN;
    logic [8:0]  PIXEL_X, PIXEL_Y;
    logic        WE_IN, SWAP_REQ, MEM_ACK;
    logic [17:0] MEM_ADDR;
    logic [7:0]  MEM_DATA;
    logic        MEM_WE, FRONT_SEL, SWAP_DONE, FULL, EMPTY, OVERFLOW;

    int checks = 0;
    int errors = 0;

    frame_buffer_writer dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_H  (RESET_H),
        .PIXEL_DIN(PIXEL_DIN),
        .PIXEL_X  (PIXEL_X),
        .PIXEL_Y  (PIXEL_Y),
        .WE_IN    (WE_IN),
        .SWAP_REQ (SWAP_REQ),
        .MEM_ACK  (MEM_ACK),
        .MEM_ADDR (MEM_ADDR),
        .MEM_DATA (MEM_DATA),
        .MEM_WE   (MEM_WE),
        .FRONT_SEL(FRONT_SEL),
        .SWAP_DONE(SWAP_DONE),
        .FULL     (FULL),
        .EMPTY    (EMPTY),
        .OVERFLOW (OVERFLOW)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Drive one valid strobe for exactly one rising edge; caller drops WE_IN afterwards.
    task automatic sendPixel(input logic [7:0] d, input logic [8:0] x, input logic [8:0] y);
        WE_IN = 1'b1; PIXEL_DIN = d; PIXEL_X = x; PIXEL_Y = y;
        @(negedge CLOCK_50);
    endtask

    task automatic test_reset();
        RESET_H = 1'b1;
        @(negedge CLOCK_50);
        RESET_H = 1'b0;
        checks++; if (MEM_WE !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we got %b want 0", MEM_WE); end
        checks++; if (FRONT_SEL !== 1'b0) begin errors++; $display("[TB] FAIL reset_front_sel got %b want 0", FRONT_SEL); end
        checks++; if (EMPTY !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty got %b want 1", EMPTY); end
        checks++; if (FULL !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got %b want 0", FULL); end
        checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got %b want 0", OVERFLOW); end
        checks++; if (SWAP_DONE !== 1'b0) begin errors++; $display("[TB] FAIL reset_swap_done got %b want 0", SWAP_DONE); end
        checks++; if (MEM_ADDR !== 18'd0) begin errors++; $display("[TB] FAIL reset_mem_addr got %h want 0", MEM_ADDR); end
    endtask

    task automatic test_single_pixel();
        MEM_ACK = 1'b1;
        sendPixel(8'h1C, 9'd5, 9'd2);
        WE_IN = 1'b0;
        checks++; if (MEM_WE !== 1'b0) begin errors++; $display("[TB] FAIL single_early1 got %b want 0", MEM_WE); end
        @(negedge CLOCK_50);
        checks++; if (MEM_WE !== 1'b0) begin errors++; $display("[TB] FAIL single_early2 got %b want 0", MEM_WE); end
        checks++; if (EMPTY !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_empty got %b want 0", EMPTY); end
        @(negedge CLOCK_50);
        checks++; if (MEM_WE !== 1'b1) begin errors++; $display("[TB] FAIL single_we got %b want 1", MEM_WE); end
        checks++; if (MEM_ADDR !== {1'b1, 17'd645}) begin errors++; $display("[TB] FAIL single_addr got %h want %h", MEM_ADDR, {1'b1, 17'd645}); end
        checks++; if (MEM_DATA !== 8'h1C) begin errors++; $display("[TB] FAIL single_data got %h want 1c", MEM_DATA); end
        @(negedge CLOCK_50);
        checks++; if (MEM_WE !== 1'b0) begin errors++; $display("[TB] FAIL single_we_drop got %b want 0", MEM_WE); end
        checks++; if (EMPTY !== 1'b1) begin errors++; $display("[TB] FAIL single_empty got %b want 1", EMPTY); end
    endtask

    task automatic test_filtering();
        int seen = 0;
        MEM_ACK = 1'b1;
        sendPixel(8'hE3, 9'd10, 9'd10);
        sendPixel(8'h1C, 9'd320, 9'd0);
        sendPixel(8'h1C, 9'd0, 9'd240);
        WE_IN = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (MEM_WE === 1'b1) seen++;
            @(negedge CLOCK_50);
        end
        checks++; if (seen != 0) begin errors++; $display("[TB] FAIL filter_writes got %0d want 0", seen); end
        checks++; if (EMPTY !== 1'b1) begin errors++; $display("[TB] FAIL filter_empty got %b want 1", EMPTY); end
    endtask

    task automatic test_backpressure();
        int n = 0;
        int firstI = -1;
        int lastI = -1;
        MEM_ACK = 1'b0;
        for (int i = 0; i < 10; i++) sendPixel(8'h40 + 8'(i), 9'(i), 9'd1);
        WE_IN = 1'b0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        checks++; if (FULL !== 1'b1) begin errors++; $display("[TB] FAIL bp_full got %b want 1", FULL); end
        checks++; if (OVERFLOW !== 1'b1) begin errors++; $display("[TB] FAIL bp_overflow got %b want 1", OVERFLOW); end
        checks++; if (MEM_WE !== 1'b1 || MEM_ADDR !== {1'b1, 17'd320}) begin errors++; $display("[TB] FAIL bp_stall_hold got we=%b addr=%h want we=1 addr=%h", MEM_WE, MEM_ADDR, {1'b1, 17'd320}); end
        MEM_ACK = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (MEM_WE === 1'b1) begin
                if (n < 8) begin
                    checks++;
                    if (MEM_ADDR !== {1'b1, 17'(320 + n)} || MEM_DATA !== 8'h40 + 8'(n)) begin
                        errors++;
                        $display("[TB] FAIL bp_order%0d got addr=%h data=%h want addr=%h data=%h", n, MEM_ADDR, MEM_DATA, {1'b1, 17'(320 + n)}, 8'h40 + 8'(n));
                    end
                end
                if (firstI < 0) firstI = i;
                lastI = i;
                n++;
            end
            @(negedge CLOCK_50);
        end
        checks++; if (n != 8) begin errors++; $display("[TB] FAIL bp_write_count got %0d want 8", n); end
        checks++; if (lastI - firstI != 7) begin errors++; $display("[TB] FAIL bp_throughput got span %0d want 7", lastI - firstI); end
        checks++; if (OVERFLOW !== 1'b1) begin errors++; $display("[TB] FAIL bp_overflow_sticky got %b want 1", OVERFLOW); end
        checks++; if (FULL !== 1'b0 || EMPTY !== 1'b1) begin errors++; $display("[TB] FAIL bp_drained got full=%b empty=%b want full=0 empty=1", FULL, EMPTY); end
    endtask

    task automatic test_swap();
        int n = 0;
        int swaps = 0;
        bit seen = 0;
        MEM_ACK = 1'b0;
        for (int i = 0; i < 3; i++) sendPixel(8'h50 + 8'(i), 9'(i), 9'd0);
        WE_IN = 1'b0;
        SWAP_REQ = 1'b1; @(negedge CLOCK_50);
        SWAP_REQ = 1'b0; @(negedge CLOCK_50);
        SWAP_REQ = 1'b1; @(negedge CLOCK_50);
        SWAP_REQ = 1'b0;
        checks++; if (SWAP_DONE !== 1'b0 || FRONT_SEL !== 1'b0) begin errors++; $display("[TB] FAIL swap_early got done=%b front=%b want 0 0", SWAP_DONE, FRONT_SEL); end
        MEM_ACK = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (MEM_WE === 1'b1) begin
                checks++;
                if (n >= 3 || MEM_ADDR !== {1'b1, 17'(n)} || MEM_DATA !== 8'h50 + 8'(n)) begin
                    errors++;
                    $display("[TB] FAIL swap_write%0d got addr=%h data=%h want addr=%h data=%h", n, MEM_ADDR, MEM_DATA, {1'b1, 17'(n)}, 8'h50 + 8'(n));
                end
                n++;
            end
            if (SWAP_DONE === 1'b1) begin
                swaps++;
                checks++; if (n != 3) begin errors++; $display("[TB] FAIL swap_before_drain got writes %0d want 3", n); end
            end
            @(negedge CLOCK_50);
        end
        checks++; if (swaps != 1) begin errors++; $display("[TB] FAIL swap_pulses got %0d want 1", swaps); end
        checks++; if (FRONT_SEL !== 1'b1) begin errors++; $display("[TB] FAIL swap_front_sel got %b want 1", FRONT_SEL); end
        checks++; if (EMPTY !== 1'b1) begin errors++; $display("[TB] FAIL swap_empty got %b want 1", EMPTY); end
        sendPixel(8'h66, 9'd7, 9'd0);
        WE_IN = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            if (MEM_WE === 1'b1) begin
                seen = 1;
                checks++;
                if (MEM_ADDR !== {1'b0, 17'd7} || MEM_DATA !== 8'h66) begin
                    errors++;
                    $display("[TB] FAIL swap_new_back got addr=%h data=%h want addr=%h data=66", MEM_ADDR, MEM_DATA, {1'b0, 17'd7});
                end
            end
            @(negedge CLOCK_50);
        end
        checks++; if (!seen) begin errors++; $display("[TB] FAIL swap_new_back_timeout got no write want one write"); end
    endtask

    task automatic test_reset_mid_write();
        int seen = 0;
        MEM_ACK = 1'b0;
        for (int i = 0; i < 4; i++) sendPixel(8'h70 + 8'(i), 9'(i), 9'd3);
        WE_IN = 1'b0;
        checks++; if (MEM_WE !== 1'b1) begin errors++; $display("[TB] FAIL midreset_stalled got %b want 1", MEM_WE); end
        RESET_H = 1'b1;
        @(negedge CLOCK_50);
        RESET_H = 1'b0;
        checks++; if (MEM_WE !== 1'b0) begin errors++; $display("[TB] FAIL midreset_we got %b want 0", MEM_WE); end
        checks++; if (MEM_ADDR !== 18'd0 || MEM_DATA !== 8'd0) begin errors++; $display("[TB] FAIL midreset_bus got addr=%h data=%h want 0 0", MEM_ADDR, MEM_DATA); end
        checks++; if (EMPTY !== 1'b1 || FULL !== 1'b0) begin errors++; $display("[TB] FAIL midreset_flags got empty=%b full=%b want 1 0", EMPTY, FULL); end
        checks++; if (FRONT_SEL !== 1'b0 || OVERFLOW !== 1'b0) begin errors++; $display("[TB] FAIL midreset_state got front=%b ovf=%b want 0 0", FRONT_SEL, OVERFLOW); end
        MEM_ACK = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (MEM_WE === 1'b1) seen++;
            @(negedge CLOCK_50);
        end
        checks++; if (seen != 0) begin errors++; $display("[TB] FAIL midreset_flushed got %0d writes want 0", seen); end
    endtask

    initial begin
        RESET_H = 1'b1; WE_IN = 1'b0; SWAP_REQ = 1'b0; MEM_ACK = 1'b0;
        PIXEL_DIN = 8'd0; PIXEL_X = 9'd0; PIXEL_Y = 9'd0;
        @(negedge CLOCK_50);
        test_reset();
        test_single_pixel();
        test_filtering();
        test_backpressure();
        test_swap();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
